// File: rtl/dlx_pkg.sv
// dlx_pkg: run-controller state/status encodings, text base and shared helpers.
package dlx_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARMED, S_RUN, S_HALT} state_e;
  typedef enum logic [1:0] {ST_NONE = 2'b00, ST_PCLIM = 2'b01, ST_TIMEOUT = 2'b10, ST_OVF = 2'b11} status_e;
  localparam logic [31:0] TEXT_BASE = 32'h00400000;
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return &v ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/dlx_run_ctrl_if.sv
// dlx_run_ctrl_if: program-load stream and imem write port of the run controller.
interface dlx_run_ctrl_if #(parameter int AW = 10);
  logic          load_valid;
  logic          load_ready;
  logic [31:0]   load_data;
  logic          load_last;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  modport master (output load_valid, load_data, load_last, input load_ready, imem_we, imem_addr, imem_wdata);
  modport slave  (input load_valid, load_data, load_last, output load_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/dlx_img_writer.sv
// dlx_img_writer: load handshake, word counter and registered imem write port.
module dlx_img_writer #(
  parameter int AW = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  dlx_run_ctrl_if.slave bus,
  output logic xfer,
  output logic full
);
  logic [AW:0]   cnt_q, cnt_d;
  logic          we_q, we_d, wr;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  // The counter never passes 2**AW because writes stop once it is full, so its MSB flags full.
  always_comb begin
    xfer    = bus.load_valid & en;
    full    = cnt_q[AW];
    wr      = xfer & ~full;
    we_d    = wr;
    cnt_d   = clr ? '0 : cnt_q + (AW+1)'(wr);
    addr_d  = wr ? cnt_q[AW-1:0] : addr_q;
    wdata_d = wr ? bus.load_data : wdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  assign bus.load_ready = en;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
endmodule

// File: rtl/dlx_run_ctrl.sv
// dlx_run_ctrl: loads the program image, releases the CPU and halts on PC limit (optional timeout via RUN_CTRL_TIMEOUT_EN).
module dlx_run_ctrl
  import dlx_pkg::*;
#(
  parameter int AW         = 10,
  parameter int MAX_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  dlx_run_ctrl_if.slave bus,
  input  logic        start,
  input  logic        clear,
  input  logic [31:0] pc_lim,
  input  logic [31:0] cpu_pc,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [31:0] cycle_count
);
`ifdef RUN_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [31:0] TO_LIM = 32'(MAX_CYCLES - 1);
  state_e      state_q, state_d;
  status_e     status_q, status_d;
  logic [31:0] cc_q, cc_d, lim_q, lim_d;
  logic        wr_en, clr, xfer, full, to_hit;
  dlx_img_writer #(.AW(AW)) u_writer (
    .clk  (clk),
    .rst  (rst),
    .en   (wr_en),
    .clr  (clr),
    .bus  (bus),
    .xfer (xfer),
    .full (full)
  );
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    cc_d     = cc_q;
    lim_d    = lim_q;
    clr      = 1'b0;
    wr_en    = state_q == S_IDLE || state_q == S_LOAD;
    to_hit   = TO_EN && cc_q == TO_LIM;
    case (state_q)
      S_IDLE: begin
        if (xfer) state_d = bus.load_last ? S_ARMED : S_LOAD;
        else if (start) begin
          state_d = S_RUN;
          lim_d   = pc_lim;
        end
      end
      S_LOAD: begin
        if (xfer && full) begin
          state_d  = S_HALT;
          status_d = ST_OVF;
        end else if (xfer && bus.load_last) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (start) begin
          state_d = S_RUN;
          lim_d   = pc_lim;
        end
      end
      S_RUN: begin
        cc_d = sat_inc(cc_q);
        // PC limit takes priority over a timeout landing on the same cycle.
        if (cpu_pc >= lim_q || to_hit) begin
          state_d  = S_HALT;
          status_d = cpu_pc >= lim_q ? ST_PCLIM : ST_TIMEOUT;
        end
      end
      S_HALT: begin
        if (clear) begin
          state_d  = S_IDLE;
          status_d = ST_NONE;
          cc_d     = '0;
          clr      = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      status_q <= ST_NONE;
      cc_q     <= '0;
      lim_q    <= TEXT_BASE;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      cc_q     <= cc_d;
      lim_q    <= lim_d;
    end
  end
  assign cpu_hold    = state_q != S_RUN;
  assign busy        = state_q == S_LOAD || state_q == S_ARMED || state_q == S_RUN;
  assign done        = state_q == S_HALT;
  assign status      = status_q;
  assign cycle_count = cc_q;
endmodule
